// File: rtl/irq_ctrl_pkg.sv
// Shared constants and types for the machine-level interrupt controller:
// register offsets inside the 64 KiB window, mcause codes, mip/mie bit
// positions, scheduler states and the priority picker.
package irq_ctrl_pkg;

    // Register offsets from the window base
    localparam logic [15:0] IRQ_OFF_MSIP        = 16'h0000;
    localparam logic [15:0] IRQ_OFF_MTIMECMP_LO = 16'h4000;
    localparam logic [15:0] IRQ_OFF_MTIMECMP_HI = 16'h4004;
    localparam logic [15:0] IRQ_OFF_MTIME_LO    = 16'hBFF8;
    localparam logic [15:0] IRQ_OFF_MTIME_HI    = 16'hBFFC;

    // mcause values for machine interrupts (interrupt flag in bit 31)
    localparam logic [31:0] MCAUSE_M_EXT_INT   = 32'h8000_000B;
    localparam logic [31:0] MCAUSE_M_SW_INT    = 32'h8000_0003;
    localparam logic [31:0] MCAUSE_M_TIMER_INT = 32'h8000_0007;

    // Bit positions shared by mip and mie
    localparam int MEIP_BIT = 11;
    localparam int MTIP_BIT = 7;
    localparam int MSIP_BIT = 3;

    // Global machine interrupt enable inside mstatus
    localparam int MSTATUS_MIE_BIT = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } irq_state_e;

    // Highest-priority cause among the enabled pending sources: MEI > MSI > MTI.
    // Only meaningful when at least one relevant bit of 'active' is set.
    function automatic logic [31:0] pick_cause(input logic [31:0] active);
        if (active[MEIP_BIT]) begin
            return MCAUSE_M_EXT_INT;
        end else if (active[MSIP_BIT]) begin
            return MCAUSE_M_SW_INT;
        end else begin
            return MCAUSE_M_TIMER_INT;
        end
    endfunction

endpackage

// File: rtl/irq_ctrl_if.sv
// Data-bus port of the interrupt controller: single-cycle write strobe,
// read strobe with registered read data one cycle later.
interface irq_ctrl_if;
    logic        wr_en;
    logic        rd_en;
    logic [31:0] addr;
    logic [31:0] wr_data;
    logic [31:0] rd_data;
    logic        rd_valid;

    modport master (
        output wr_en, rd_en, addr, wr_data,
        input  rd_data, rd_valid
    );

    modport slave (
        input  wr_en, rd_en, addr, wr_data,
        output rd_data, rd_valid
    );
endinterface

// File: rtl/irq_ctrl_timer.sv
// Machine timer: tick divider, 64-bit mtime and mtimecmp with their bus
// write paths, a combinational read view of the four timer words and the
// raw (unregistered) timer-pending compare.
module irq_ctrl_timer
    import irq_ctrl_pkg::*;
#(
    parameter int TICK_DIV = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_en,      // already qualified by the window decode
    input  logic [15:0] offset,
    input  logic [31:0] wr_data,
    output logic [31:0] rd_data,    // 0 when offset is not a timer word
    output logic        mtip
);

    localparam int              CNT_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] tick_cnt_q, tick_cnt_d;
    logic [63:0]      mtime_q, mtime_d;
    logic [63:0]      mtimecmp_q, mtimecmp_d;
    logic [63:0]      mtime_inc;
    logic             tick;

    // Next-state for divider, mtime and mtimecmp; a bus write to one half of
    // mtime overrides only that half, the other half still takes the carry.
    always_comb begin
        tick       = (tick_cnt_q == TICK_LAST);
        tick_cnt_d = tick ? '0 : tick_cnt_q + CNT_W'(1);
        mtime_inc  = tick ? mtime_q + 64'd1 : mtime_q;

        mtime_d    = mtime_inc;
        mtimecmp_d = mtimecmp_q;
        if (wr_en) begin
            case (offset)
                IRQ_OFF_MTIME_LO:    mtime_d[31:0]     = wr_data;
                IRQ_OFF_MTIME_HI:    mtime_d[63:32]    = wr_data;
                IRQ_OFF_MTIMECMP_LO: mtimecmp_d[31:0]  = wr_data;
                IRQ_OFF_MTIMECMP_HI: mtimecmp_d[63:32] = wr_data;
                default: ;
            endcase
        end
    end

    // Read view of the current (pre-write) timer registers
    always_comb begin
        rd_data = '0;
        case (offset)
            IRQ_OFF_MTIME_LO:    rd_data = mtime_q[31:0];
            IRQ_OFF_MTIME_HI:    rd_data = mtime_q[63:32];
            IRQ_OFF_MTIMECMP_LO: rd_data = mtimecmp_q[31:0];
            IRQ_OFF_MTIMECMP_HI: rd_data = mtimecmp_q[63:32];
            default: ;
        endcase
    end

    assign mtip = (mtime_q >= mtimecmp_q);

    // Timer state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt_q <= '0;
            mtime_q    <= '0;
            mtimecmp_q <= '1;
        end else begin
            tick_cnt_q <= tick_cnt_d;
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
        end
    end

endmodule

// File: rtl/irq_ctrl.sv
// Machine-level interrupt controller: window decode and msip register,
// external-line synchroniser, registered mip vector and the req/ack
// scheduler that hands one interrupt at a time to the trap sequencer.
module irq_ctrl
    import irq_ctrl_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h0200_0000,
    parameter int          TICK_DIV    = 1,
    parameter int          SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    irq_ctrl_if.slave   bus,
    input  logic        i_ext_irq,
    input  logic [31:0] i_csr_mstatus,
    input  logic [31:0] i_csr_mie,
    input  logic        i_clint_mode,
    output logic [31:0] o_mip,
    output logic        o_irq_req,
    output logic [31:0] o_irq_cause,
    input  logic        i_irq_ack
);

    logic [15:0]            offset;
    logic                   in_win, wr_hit, rd_hit;
    logic [31:0]            timer_rd_data;
    logic                   timer_mtip;

    logic                   msip_q, msip_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [31:0]            mip_q, mip_d;
    logic [31:0]            rd_data_q, rd_data_d;
    logic                   rd_valid_q, rd_valid_d;
    irq_state_e             state_q, state_d;
    logic                   req_q, req_d;
    logic [31:0]            cause_q, cause_d;
    logic [31:0]            active;

    logic                   unused_mstatus;
    assign unused_mstatus = ^{i_csr_mstatus[31:4], i_csr_mstatus[2:0]};

    // Only the upper half of the address selects the 64 KiB window
    assign offset = bus.addr[15:0];
    assign in_win = (bus.addr[31:16] == BASE_ADDR[31:16]);
    assign wr_hit = bus.wr_en & in_win;
    assign rd_hit = bus.rd_en & in_win;

    irq_ctrl_timer #(
        .TICK_DIV (TICK_DIV)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_hit),
        .offset  (offset),
        .wr_data (bus.wr_data),
        .rd_data (timer_rd_data),
        .mtip    (timer_mtip)
    );

    // msip write, read mux, synchroniser shift and next pending vector
    always_comb begin
        msip_d = msip_q;
        if (wr_hit && (offset == IRQ_OFF_MSIP)) begin
            msip_d = bus.wr_data[0];
        end

        rd_valid_d = rd_hit;
        rd_data_d  = '0;
        if (rd_hit) begin
            if (offset == IRQ_OFF_MSIP) begin
                rd_data_d = {31'd0, msip_q};
            end else begin
                rd_data_d = timer_rd_data;
            end
        end

        sync_d = {sync_q[SYNC_STAGES-2:0], i_ext_irq};

        mip_d           = '0;
        mip_d[MEIP_BIT] = sync_q[SYNC_STAGES-1];
        mip_d[MTIP_BIT] = timer_mtip;
        mip_d[MSIP_BIT] = msip_q;
    end

    // Scheduler: raise one request, hold it until ack, then wait out the trap
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        cause_d = cause_q;
        active  = mip_q & i_csr_mie;
        case (state_q)
            ST_IDLE: begin
                if (i_csr_mstatus[MSTATUS_MIE_BIT] && (|active) && !i_clint_mode) begin
                    cause_d = pick_cause(active);
                    req_d   = 1'b1;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (i_irq_ack) begin
                    req_d   = 1'b0;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!i_clint_mode) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                req_d   = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control, pending and bus-response registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            msip_q     <= 1'b0;
            sync_q     <= '0;
            mip_q      <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            state_q    <= ST_IDLE;
            req_q      <= 1'b0;
            cause_q    <= '0;
        end else begin
            msip_q     <= msip_d;
            sync_q     <= sync_d;
            mip_q      <= mip_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            state_q    <= state_d;
            req_q      <= req_d;
            cause_q    <= cause_d;
        end
    end

    assign o_mip        = mip_q;
    assign o_irq_req    = req_q;
    assign o_irq_cause  = cause_q;
    assign bus.rd_data  = rd_data_q;
    assign bus.rd_valid = rd_valid_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Bench for irq_ctrl: a cycle-level reference model of the controller's
// visible behaviour plus directed scenarios with literal expectations.
module tb_irq_ctrl;

    localparam int TICK_DIV = 1;

    localparam logic [31:0] A_MSIP   = 32'h0200_0000;
    localparam logic [31:0] A_CMP_LO = 32'h0200_4000;
    localparam logic [31:0] A_CMP_HI = 32'h0200_4004;
    localparam logic [31:0] A_MT_LO  = 32'h0200_BFF8;
    localparam logic [31:0] A_MT_HI  = 32'h0200_BFFC;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        ext = 1'b0;
    logic [31:0] mstatus = '0;
    logic [31:0] mie = '0;
    logic        clint = 1'b0;
    logic        ack = 1'b0;
    logic [31:0] o_mip, o_irq_cause;
    logic        o_irq_req;

    irq_ctrl_if bus_if();

    irq_ctrl #(
        .BASE_ADDR   (32'h0200_0000),
        .TICK_DIV    (TICK_DIV),
        .SYNC_STAGES (2)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .bus           (bus_if),
        .i_ext_irq     (ext),
        .i_csr_mstatus (mstatus),
        .i_csr_mie     (mie),
        .i_clint_mode  (clint),
        .o_mip         (o_mip),
        .o_irq_req     (o_irq_req),
        .o_irq_cause   (o_irq_cause),
        .i_irq_ack     (ack)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model state (what the spec says is architecturally visible)
    logic [63:0] m_mtime, m_cmp;
    logic        m_msip;
    logic [1:0]  m_sync;
    logic [31:0] m_mip, m_cause, m_rdd;
    logic        m_req, m_wait, m_rdv;
    int          m_tick;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_reg(input logic [15:0] off);
        case (off)
            16'h0000: return {31'd0, m_msip};
            16'h4000: return m_cmp[31:0];
            16'h4004: return m_cmp[63:32];
            16'hBFF8: return m_mtime[31:0];
            16'hBFFC: return m_mtime[63:32];
            default:  return 32'd0;
        endcase
    endfunction

    task automatic model_reset();
        m_mtime = '0;  m_cmp = '1;  m_msip = 1'b0;  m_sync = '0;  m_mip = '0;
        m_cause = '0;  m_rdd = '0;  m_req = 1'b0;   m_wait = 1'b0; m_rdv = 1'b0;
        m_tick  = 0;
    endtask

    task automatic model_step();
        logic        win;
        logic [15:0] off;
        logic [31:0] act, nmip;
        win = (bus_if.addr[31:16] == 16'h0200);
        off = bus_if.addr[15:0];
        // reads see the values from before this edge
        m_rdv = bus_if.rd_en && win;
        m_rdd = m_rdv ? m_reg(off) : 32'd0;
        // scheduler decisions use the currently visible mip
        act = m_mip & mie;
        if (m_req) begin
            if (ack) begin m_req = 1'b0; m_wait = 1'b1; end
        end else if (m_wait) begin
            if (!clint) m_wait = 1'b0;
        end else if (mstatus[3] && (act != 0) && !clint) begin
            m_req   = 1'b1;
            m_cause = act[11] ? 32'h8000_000B : (act[3] ? 32'h8000_0003 : 32'h8000_0007);
        end
        nmip     = '0;
        nmip[11] = m_sync[1];
        nmip[7]  = (m_mtime >= m_cmp);
        nmip[3]  = m_msip;
        m_sync   = {m_sync[0], ext};
        m_tick++;
        if (m_tick == TICK_DIV) begin
            m_tick  = 0;
            m_mtime = m_mtime + 64'd1;
        end
        if (bus_if.wr_en && win) begin
            case (off)
                16'h0000: m_msip = bus_if.wr_data[0];
                16'h4000: m_cmp[31:0] = bus_if.wr_data;
                16'h4004: m_cmp[63:32] = bus_if.wr_data;
                16'hBFF8: m_mtime[31:0] = bus_if.wr_data;
                16'hBFFC: m_mtime[63:32] = bus_if.wr_data;
                default: ;
            endcase
        end
        m_mip = nmip;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        bus_if.wr_en = 1'b1; bus_if.addr = a; bus_if.wr_data = d;
        @(negedge clk);
        bus_if.wr_en = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d, output logic v);
        bus_if.rd_en = 1'b1; bus_if.addr = a;
        @(negedge clk);
        bus_if.rd_en = 1'b0;
        d = bus_if.rd_data;
        v = bus_if.rd_valid;
    endtask

    task automatic rd_chk(input string nm, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] d;
        logic        v;
        bus_read(a, d, v);
        chk({nm, "_vld"}, {31'd0, v}, 32'd1);
        chk(nm, d, exp);
    endtask

    task automatic wait_req(input int n, input string nm);
        int k;
        k = 0;
        while (!o_irq_req && k < n) begin
            @(negedge clk);
            k++;
        end
        chk(nm, {31'd0, o_irq_req}, 32'd1);
    endtask

    task automatic ack_trap();
        ack = 1'b1; clint = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        chk("req_drop_after_ack", {31'd0, o_irq_req}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        logic        v;
        logic        seen;
        int          k;

        bus_if.wr_en = 1'b0; bus_if.rd_en = 1'b0;
        bus_if.addr = '0;    bus_if.wr_data = '0;
        model_reset();
        #1 rst_n = 1'b0;

        fork
            // reference model, advanced on the same events as the DUT
            forever begin
                @(posedge clk or negedge rst_n);
                if (!rst_n) model_reset();
                else        model_step();
            end
            // per-cycle comparison against the model
            forever begin
                @(negedge clk);
                chk("mip",      o_mip, m_mip);
                chk("irq_req",  {31'd0, o_irq_req}, {31'd0, m_req});
                chk("cause",    o_irq_cause, m_cause);
                chk("rd_valid", {31'd0, bus_if.rd_valid}, {31'd0, m_rdv});
                chk("rd_data",  bus_if.rd_data, m_rdd);
            end
        join_none

        repeat (3) @(negedge clk);

        // Reset values; the first read leaves reset together with rst_n
        rst_n = 1'b1;
        rd_chk("rst_mtime_lo", A_MT_LO, 32'h0);
        rd_chk("rst_cmp_lo",   A_CMP_LO, 32'hFFFF_FFFF);
        rd_chk("rst_cmp_hi",   A_CMP_HI, 32'hFFFF_FFFF);
        rd_chk("rst_msip",     A_MSIP,   32'h0);
        chk("rst_req", {31'd0, o_irq_req}, 32'd0);
        chk("rst_mip", o_mip, 32'd0);

        // Window decode: unmapped in-window, out-of-window read and write
        rd_chk("unmapped_rd", 32'h0200_1000, 32'h0);
        bus_read(32'h0300_0000, d, v);
        chk("outwin_rd_vld", {31'd0, v}, 32'd0);
        bus_write(32'h0201_0000, 32'h1);
        rd_chk("outwin_wr_ignored", A_MSIP, 32'h0);

        // Read coinciding with a write returns the old value
        bus_if.wr_en = 1'b1; bus_if.rd_en = 1'b1;
        bus_if.addr = A_MSIP; bus_if.wr_data = 32'hFFFF_FFFF;
        @(negedge clk);
        bus_if.wr_en = 1'b0; bus_if.rd_en = 1'b0;
        chk("rw_same_old", bus_if.rd_data, 32'h0);
        rd_chk("msip_bit0_only", A_MSIP, 32'h1);
        bus_write(A_MSIP, 32'h0);

        // Timer interrupt at mtime == 20
        mstatus = 32'h8; mie = 32'h80;
        bus_write(A_MT_LO, 32'd0);
        bus_write(A_MT_HI, 32'd0);
        bus_write(A_CMP_LO, 32'd20);
        bus_write(A_CMP_HI, 32'd0);
        k = 0;
        while (!o_mip[7] && k < 60) begin @(negedge clk); k++; end
        chk("mtip_seen", {31'd0, o_mip[7]}, 32'd1);
        chk("mtip_req_not_yet", {31'd0, o_irq_req}, 32'd0);
        @(negedge clk);
        chk("mti_req_next", {31'd0, o_irq_req}, 32'd1);
        chk("mti_cause", o_irq_cause, 32'h8000_0007);
        ack_trap();
        repeat (5) @(negedge clk);
        chk("wait_holds", {31'd0, o_irq_req}, 32'd0);
        clint = 1'b0;
        @(negedge clk);
        chk("wait_exit_gap", {31'd0, o_irq_req}, 32'd0);
        @(negedge clk);
        chk("mti_reissue", {31'd0, o_irq_req}, 32'd1);
        ack_trap();
        bus_write(A_CMP_HI, 32'hFFFF_FFFF);
        repeat (2) @(negedge clk);
        clint = 1'b0;
        repeat (3) @(negedge clk);
        chk("mti_cleared", {31'd0, o_mip[7]}, 32'd0);

        // External beats software; software follows when external drops
        mie = 32'h0; ext = 1'b1;
        bus_write(A_MSIP, 32'h1);
        repeat (5) @(negedge clk);
        mie = 32'h888;
        wait_req(4, "mei_req1");
        chk("mei_cause1", o_irq_cause, 32'h8000_000B);
        chk("msip_still_pending", {31'd0, o_mip[3]}, 32'd1);
        ack_trap();
        repeat (3) @(negedge clk);
        clint = 1'b0;
        wait_req(4, "mei_req2");
        chk("mei_cause2", o_irq_cause, 32'h8000_000B);
        ack_trap();
        ext = 1'b0;
        repeat (6) @(negedge clk);
        clint = 1'b0;
        wait_req(4, "msi_req");
        chk("msi_cause", o_irq_cause, 32'h8000_0003);
        ack_trap();
        bus_write(A_MSIP, 32'h0);
        repeat (3) @(negedge clk);
        clint = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_no_req", {31'd0, o_irq_req}, 32'd0);

        // Global MIE gates everything
        mstatus = 32'h0; mie = 32'h8;
        bus_write(A_MSIP, 32'h1);
        seen = 1'b0;
        repeat (50) begin @(negedge clk); if (o_irq_req) seen = 1'b1; end
        chk("no_req_mie_off", {31'd0, seen}, 32'd0);
        mstatus = 32'h8;
        wait_req(2, "req_after_mie");
        chk("mie_cause", o_irq_cause, 32'h8000_0003);
        ack_trap();
        bus_write(A_MSIP, 32'h0);
        clint = 1'b0;
        repeat (3) @(negedge clk);

        // mtime low-word carry into the high word
        mie = 32'h0;
        bus_write(A_MT_HI, 32'h0);
        bus_write(A_MT_LO, 32'hFFFF_FFFF);
        @(negedge clk);
        rd_chk("wrap_lo", A_MT_LO, 32'h0);
        rd_chk("wrap_hi", A_MT_HI, 32'h1);

        // Asynchronous reset in the middle of a request
        mstatus = 32'h8; mie = 32'h8;
        bus_write(A_MSIP, 32'h1);
        wait_req(4, "pre_reset_req");
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async_req",   {31'd0, o_irq_req}, 32'd0);
        chk("rst_async_mip",   o_mip, 32'd0);
        chk("rst_async_cause", o_irq_cause, 32'd0);
        chk("rst_async_rdv",   {31'd0, bus_if.rd_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        rd_chk("rst2_mtime_hi", A_MT_HI, 32'h0);
        rd_chk("rst2_cmp_hi",   A_CMP_HI, 32'hFFFF_FFFF);
        rd_chk("rst2_msip",     A_MSIP,   32'h0);
        repeat (3) @(negedge clk);
        chk("rst2_no_req", {31'd0, o_irq_req}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
